imm_decode_stage: RTL
=====================

# imm_decode_stage

Pipelined, parametrised immediate decoder that sits between fetch and the register-read/execute stage. It derives the immediate format directly from the instruction opcode and emits the XLEN-wide extended immediate one cycle later. It uses a valid/ready handshake with a skid buffer, so back-pressure from execute never drops or duplicates an instruction. It adds CSR zimm decode, RV64 support, flush, illegal-opcode flagging and optional compressed immediates.

## Interface
- XLEN, 32, datapath width of the immediate output; legal values 32 or 64.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  instruction word present
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  instruction word; a 16-bit instruction occupies bits 15:0
- out_valid  output  1  decoded result present
- out_ready  input  1  downstream accepts this cycle
- out_imm  output  XLEN  extended immediate
- out_fmt  output  3  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 C (compressed)
- out_illegal  output  1  opcode not recognised

## Operation
- Decode uses opcode bits [6:0]:
  - 0000011, 0010011, 1100111, 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → R; imm = 0.
  - 1110011 → Z if funct3[2] = 1, otherwise I.
- XLEN = 64 only: 0011011 → I and 0111011 → R. With XLEN = 32 these two opcodes are illegal.
- Immediate construction:
  - I: sign-extend instr[31:20].
  - S: sign-extend {instr[31:25], instr[11:7]}.
  - B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: zero-extend instr[19:15].
- All sign extension replicates instr[31] up to XLEN.
- Unrecognised opcode, or instr[1:0] != 2'b11 without compressed support → out_illegal = 1, imm = 0, fmt = 0. The entry still flows through the handshake.
- Storage is a main output register plus a one-entry skid register.
- States: EMPTY (no valid output), ONE (output register valid), FULL (output and skid both valid).
- Transitions:
  - EMPTY → ONE on accept.
  - ONE → ONE on accept with out_ready, or on no accept with no out_ready.
  - ONE → EMPTY on out_ready with no accept.
  - ONE → FULL on accept with !out_ready.
  - FULL → ONE on out_ready; the skid entry moves to the output register.
- Accept = in_valid && in_ready. in_ready = 1 in EMPTY and ONE, 0 in FULL.
- Output fields are held stable while out_valid && !out_ready.
- flush → next state EMPTY. Any instruction accepted in the same cycle is discarded. Flush has priority over every other event.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Throughput is 1 per cycle while out_ready = 1.
- in_ready depends only on registered state, with no combinational path from out_ready.
- Reset (asserted at any time, including mid-stall): out_valid = 0, out_imm = 0, out_fmt = 0, out_illegal = 0, in_ready = 1, state EMPTY. The skid register is cleared.
- Order is preserved: the skid entry is always older than any newly accepted entry.

## Configuration
- IMM_RVC_EN defined: instr[1:0] != 2'b11 selects compressed decode with fmt = 7. Covered instructions and immediates are per the RVC spec:
  - C.ADDI4SPN: zero-extended.
  - C.LW/C.SW: zero-extended offset.
  - C.ADDI/C.LI/C.ADDI16SP: sign-extended.
  - C.LUI: sign-extended, shifted by 12.
  - C.J/C.JAL: sign-extended.
  - C.BEQZ/C.BNEZ: sign-extended.
  - C.LWSP/C.SWSP: zero-extended.
  - Any other compressed encoding → illegal.
- IMM_RVC_EN undefined: all compressed encodings → out_illegal = 1, imm = 0, fmt = 0. No compressed decode logic is present.

## Test plan
- Basic formats, back-to-back with out_ready = 1:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt 1.
  - 0xFE000EE3 → imm 0xFFFFFFFC, fmt 3.
  - 0x123450B7 → imm 0x12345000, fmt 4.
  - 0x3002D073 → imm 0x00000005, fmt 6.
  - Each result appears exactly one cycle after accept.
- Back-pressure: stream 4 instructions with out_ready low for 3 cycles.
  - in_ready drops after the 2nd accept.
  - Outputs are held stable while stalled.
  - All 4 emerge in order, with no loss or duplication.
- Flush while FULL, with in_valid = 1 in the same cycle:
  - Next cycle out_valid = 0 and in_ready = 1.
  - The flushed instructions never appear on the output.
- Illegal input: 0x0000007F → out_illegal = 1, imm 0, fmt 0. Repeat with XLEN = 32 and opcode 0011011 → illegal.
- XLEN = 64: 0x123450B7 → imm 0x0000000012345000; 0x800000B7 → 0xFFFFFFFF80000000.
- Compressed: 0x50FD (C.LI x1,-1) → imm all-ones, fmt 7 with IMM_RVC_EN defined, or out_illegal = 1 without it. Assert reset mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Immediate decoder stage: opcode-driven format/immediate decode, one-cycle latency,
// valid/ready with a one-entry skid buffer. Define IMM_RVC_EN to add compressed decode.
module imm_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
   localparam logic [2:0] FMT_Z = 3'd6;
`ifdef IMM_RVC_EN
   localparam logic [2:0] FMT_C = 3'd7;
`endif

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   // Candidate immediates; the sign bit instr[31] is folded into the replication.
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
   assign imm_i = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
   assign imm_s = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
   assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   assign imm_z = {{(XLEN-5){1'b0}}, in_instr[19:15]};

`ifdef IMM_RVC_EN
   logic [15:0]     c;
   logic [XLEN-1:0] rvc_imm;
   logic            rvc_illegal;
   assign c = in_instr[15:0];

   always_comb begin
      rvc_imm     = '0;
      rvc_illegal = 1'b0;
      case ({c[1:0], c[15:13]})
         5'b00_000: begin // C.ADDI4SPN, zero nzuimm is reserved
            rvc_imm     = {{(XLEN-10){1'b0}}, c[10:7], c[12:11], c[5], c[6], 2'b00};
            rvc_illegal = (c[12:5] == 8'h00);
         end
         5'b00_010, 5'b00_110:
            rvc_imm = {{(XLEN-7){1'b0}}, c[5], c[12:10], c[6], 2'b00};
         5'b01_000, 5'b01_010:
            rvc_imm = {{(XLEN-5){c[12]}}, c[6:2]};
         5'b01_001: begin // C.JAL exists only on RV32
            if (XLEN == 32)
               rvc_imm = {{(XLEN-11){c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
            else
               rvc_illegal = 1'b1;
         end
         5'b01_011: begin
            if (c[11:7] == 5'd2)
               rvc_imm = {{(XLEN-9){c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
            else
               rvc_imm = {{(XLEN-17){c[12]}}, c[6:2], 12'b0};
            rvc_illegal = ({c[12], c[6:2]} == 6'd0);
         end
         5'b01_101:
            rvc_imm = {{(XLEN-11){c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
         5'b01_110, 5'b01_111:
            rvc_imm = {{(XLEN-8){c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
         5'b10_010:
            rvc_imm = {{(XLEN-8){1'b0}}, c[3:2], c[12], c[6:4], 2'b00};
         5'b10_110:
            rvc_imm = {{(XLEN-8){1'b0}}, c[8:7], c[12:9], 2'b00};
         default:
            rvc_illegal = 1'b1;
      endcase
      if (rvc_illegal)
         rvc_imm = '0;
   end
`endif

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;

   always_comb begin
      dec_imm     = '0;
      dec_fmt     = FMT_R;
      dec_illegal = 1'b0;
      if (in_instr[1:0] != 2'b11) begin
`ifdef IMM_RVC_EN
         dec_illegal = rvc_illegal;
         if (!rvc_illegal) begin
            dec_fmt = FMT_C;
            dec_imm = rvc_imm;
         end
`else
         dec_illegal = 1'b1;
`endif
      end else begin
         case (in_instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
               dec_fmt = FMT_I;
               dec_imm = imm_i;
            end
            OP_STORE: begin
               dec_fmt = FMT_S;
               dec_imm = imm_s;
            end
            OP_BRANCH: begin
               dec_fmt = FMT_B;
               dec_imm = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
               dec_fmt = FMT_U;
               dec_imm = imm_u;
            end
            OP_JAL: begin
               dec_fmt = FMT_J;
               dec_imm = imm_j;
            end
            OP_REG: dec_fmt = FMT_R;
            OP_SYSTEM: begin // funct3[2] selects the CSR immediate forms
               dec_fmt = in_instr[14] ? FMT_Z : FMT_I;
               dec_imm = in_instr[14] ? imm_z : imm_i;
            end
            OP_IMM32: begin
               if (XLEN == 64) begin
                  dec_fmt = FMT_I;
                  dec_imm = imm_i;
               end else begin
                  dec_illegal = 1'b1;
               end
            end
            OP_REG32: dec_illegal = (XLEN != 64);
            default:  dec_illegal = 1'b1;
         endcase
      end
   end

   state_t          state_reg;
   logic [XLEN-1:0] out_imm_reg, skid_imm_reg;
   logic [2:0]      out_fmt_reg, skid_fmt_reg;
   logic            out_illegal_reg, skid_illegal_reg;
   logic            accept;

   assign in_ready    = (state_reg != FULL);
   assign out_valid   = (state_reg != EMPTY);
   assign accept      = in_valid && in_ready;
   assign out_imm     = out_imm_reg;
   assign out_fmt     = out_fmt_reg;
   assign out_illegal = out_illegal_reg;

   // The skid register only ever holds an entry older than the next accepted one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= EMPTY;
         out_imm_reg      <= '0;
         out_fmt_reg      <= FMT_R;
         out_illegal_reg  <= 1'b0;
         skid_imm_reg     <= '0;
         skid_fmt_reg     <= FMT_R;
         skid_illegal_reg <= 1'b0;
      end else if (flush) begin
         state_reg <= EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  out_imm_reg     <= dec_imm;
                  out_fmt_reg     <= dec_fmt;
                  out_illegal_reg <= dec_illegal;
                  state_reg       <= ONE;
               end
            end
            ONE: begin
               if (accept && out_ready) begin
                  out_imm_reg     <= dec_imm;
                  out_fmt_reg     <= dec_fmt;
                  out_illegal_reg <= dec_illegal;
               end else if (accept) begin
                  skid_imm_reg     <= dec_imm;
                  skid_fmt_reg     <= dec_fmt;
                  skid_illegal_reg <= dec_illegal;
                  state_reg        <= FULL;
               end else if (out_ready) begin
                  state_reg <= EMPTY;
               end
            end
            FULL: begin
               if (out_ready) begin
                  out_imm_reg     <= skid_imm_reg;
                  out_fmt_reg     <= skid_fmt_reg;
                  out_illegal_reg <= skid_illegal_reg;
                  state_reg       <= ONE;
               end
            end
            default: state_reg <= EMPTY;
         endcase
      end
   end

endmodule
